// File: rtl/axi_sched_pkg.sv
// Shared types and read-address map for the AR-channel scheduler.
// decode_slave returns NUM_MAPPED when no explicit region matches (default slave).
package axi_sched_pkg;

  typedef enum logic [0:0] {IDLE, ADDR} ar_state_e;

  localparam int unsigned MAP_AW     = 32;
  localparam int unsigned NUM_MAPPED = 2;

  localparam logic [MAP_AW-1:0] SLV_BASE [NUM_MAPPED] = '{32'h0000_0000, 32'h0001_0000};
  localparam logic [MAP_AW-1:0] SLV_MASK [NUM_MAPPED] = '{32'hFFFF_0000, 32'hFFFF_0000};

  function automatic int unsigned decode_slave(input logic [MAP_AW-1:0] addr);
    int unsigned hit;
    hit = NUM_MAPPED;
    // Descending scan so the lowest matching region wins.
    for (int s = NUM_MAPPED - 1; s >= 0; s--) begin
      if ((addr & SLV_MASK[s]) == SLV_BASE[s]) hit = s;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of eligible at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned IW1 = IW + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;

  // Rotate so that bit 0 of rot corresponds to the pointer position.
  assign dbl = {eligible, eligible};
  assign rot = N'(dbl >> ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = IW1'(ptr) + IW1'(k);
        if (sum >= IW1'(N)) sum = sum - IW1'(N);
        idx   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ar_rr_scheduler.sv
// AR-channel scheduler: round-robin master arbitration, address decode to slaves,
// and per-slave blocking while a read burst is open (released on R handshake with RLAST).
module ar_rr_scheduler
  import axi_sched_pkg::*;
#(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned NUM_S = 3,
  parameter int unsigned ADDRW = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M-1:0]         arvalid_m,
  input  logic [NUM_M*ADDRW-1:0]   araddr_m,
  output logic [NUM_M-1:0]         arready_m,
  output logic [NUM_S-1:0]         arvalid_s,
  input  logic [NUM_S-1:0]         arready_s,
  input  logic [NUM_S-1:0]         rvalid_s,
  input  logic [NUM_S-1:0]         rready_s,
  input  logic [NUM_S-1:0]         rlast_s,
  output logic [$clog2(NUM_M)-1:0] sel_m,
  output logic [NUM_S-1:0]         busy_s
);

  localparam int unsigned MW = $clog2(NUM_M);
  localparam int unsigned SW = $clog2(NUM_S);

  ar_state_e       state_q;
  logic [MW-1:0]   sel_q;
  logic [MW-1:0]   rr_ptr_q;
  logic [SW-1:0]   tgt_q;
  logic [NUM_S-1:0] busy_q;
  logic [NUM_S-1:0] busy_d;

  logic [SW-1:0]    dec_slv [NUM_M];
  logic [NUM_M-1:0] elig;
  logic [MW-1:0]    pick_idx;
  logic             pick_found;
  logic             hs;
  logic [NUM_S-1:0] set_vec;
  logic [NUM_S-1:0] clr_vec;
  logic [MW-1:0]    ptr_next;

  always_comb begin
    int unsigned dec_idx;
    dec_idx = 0;
    for (int i = 0; i < NUM_M; i++) begin
      dec_idx    = decode_slave(MAP_AW'(araddr_m[i*ADDRW +: ADDRW]));
      // Anything outside the explicit map lands on the default (last) slave.
      dec_slv[i] = (dec_idx >= NUM_S - 1) ? SW'(NUM_S - 1) : SW'(dec_idx);
      elig[i]    = arvalid_m[i] & ~busy_q[dec_slv[i]];
    end
  end

  rr_picker #(
    .N (NUM_M)
  ) u_picker (
    .eligible (elig),
    .ptr      (rr_ptr_q),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  always_comb begin
    arvalid_s = '0;
    arready_m = '0;
    if (state_q == ADDR) begin
      arvalid_s[tgt_q] = arvalid_m[sel_q];
      arready_m[sel_q] = arready_s[tgt_q];
    end
  end

  assign hs       = (state_q == ADDR) & arvalid_m[sel_q] & arready_s[tgt_q];
  assign set_vec  = hs ? (NUM_S'(1) << tgt_q) : '0;
  assign clr_vec  = rvalid_s & rready_s & rlast_s;
  // Clear after set so a forced same-cycle set/clear leaves the slave free.
  assign busy_d   = (busy_q | set_vec) & ~clr_vec;
  assign ptr_next = (sel_q == MW'(NUM_M - 1)) ? '0 : sel_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      tgt_q    <= '0;
      rr_ptr_q <= '0;
      busy_q   <= '0;
    end else begin
      busy_q <= busy_d;
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            sel_q   <= pick_idx;
            tgt_q   <= dec_slv[pick_idx];
            state_q <= ADDR;
          end
        end
        ADDR: begin
          // A master withdrawing ARVALID abandons the grant without touching the pointer.
          if (!arvalid_m[sel_q]) begin
            state_q <= IDLE;
          end else if (arready_s[tgt_q]) begin
            rr_ptr_q <= ptr_next;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_m  = sel_q;
  assign busy_s = busy_q;

endmodule

// File: tb/tb_ar_rr_scheduler.sv
// Directed bench for ar_rr_scheduler: reset, single read, round-robin, busy skip,
// default slave, backpressure with asynchronous reset mid-operation.
module tb_ar_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  arvalid_m = '0;
  logic [63:0] araddr_m = '0;
  logic [1:0]  arready_m;
  logic [2:0]  arvalid_s;
  logic [2:0]  arready_s = '0;
  logic [2:0]  rvalid_s = '0;
  logic [2:0]  rready_s = '0;
  logic [2:0]  rlast_s = '0;
  logic [0:0]  sel_m;
  logic [2:0]  busy_s;

  int n_checks = 0;
  int n_errors = 0;

  ar_rr_scheduler #(
    .NUM_M (2),
    .NUM_S (3),
    .ADDRW (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arvalid_m (arvalid_m),
    .araddr_m  (araddr_m),
    .arready_m (arready_m),
    .arvalid_s (arvalid_s),
    .arready_s (arready_s),
    .rvalid_s  (rvalid_s),
    .rready_s  (rready_s),
    .rlast_s   (rlast_s),
    .sel_m     (sel_m),
    .busy_s    (busy_s)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rlast_pulse(input logic [2:0] slv);
    rvalid_s = slv;
    rready_s = slv;
    rlast_s  = slv;
    cyc();
    rvalid_s = '0;
    rready_s = '0;
    rlast_s  = '0;
    settle();
  endtask

  initial begin
    // 1. Reset held with both masters requesting
    #1 rst = 1'b1;
    arvalid_m = 2'b11;
    araddr_m  = {32'h0001_0000, 32'h0000_0010};
    arready_s = 3'b111;
    settle();
    for (int k = 0; k < 3; k++) begin
      chk("rst_arvalid_s", 32'(arvalid_s), 32'h0);
      chk("rst_arready_m", 32'(arready_m), 32'h0);
      chk("rst_busy_s",    32'(busy_s),    32'h0);
      chk("rst_sel_m",     32'(sel_m),     32'h0);
      cyc();
    end
    arvalid_m = 2'b00;
    arready_s = 3'b000;
    rst = 1'b0;
    settle();

    // 2. Single read M0 -> S0, then RLAST release
    arvalid_m = 2'b01;
    araddr_m  = {32'h0000_0000, 32'h0000_0010};
    arready_s = 3'b001;
    settle();
    chk("single_decision_idle", 32'(arvalid_s), 32'h0);
    cyc();
    chk("single_arvalid_s", 32'(arvalid_s), 32'b001);
    chk("single_arready_m", 32'(arready_m), 32'b01);
    chk("single_sel_m",     32'(sel_m),     32'h0);
    cyc();
    arvalid_m = 2'b00;
    settle();
    chk("single_busy_set",  32'(busy_s),    32'b001);
    chk("single_idle_after", 32'(arvalid_s), 32'h0);
    rlast_pulse(3'b001);
    chk("single_busy_clr",  32'(busy_s),    32'b000);

    // 3. Round-robin: both masters to S1, pointer restarted at 0
    rst = 1'b1;
    settle();
    rst = 1'b0;
    arvalid_m = 2'b11;
    araddr_m  = {32'h0001_0000, 32'h0001_0000};
    arready_s = 3'b010;
    settle();
    for (int k = 0; k < 4; k++) begin
      chk("rr_idle", 32'(arvalid_s), 32'h0);
      cyc();
      chk("rr_sel_m",     32'(sel_m),     32'(k % 2));
      chk("rr_arvalid_s", 32'(arvalid_s), 32'b010);
      chk("rr_arready_m", 32'(arready_m), 32'(1 << (k % 2)));
      cyc();
      chk("rr_busy_set",  32'(busy_s),    32'b010);
      chk("rr_blocked",   32'(arvalid_s), 32'h0);
      rlast_pulse(3'b010);
      chk("rr_busy_clr",  32'(busy_s),    32'b000);
    end
    arvalid_m = 2'b00;
    arready_s = 3'b000;
    settle();

    // 4. Busy skip: S0 made busy by M1 (pointer returns to 0), then M0->S0 skipped
    arvalid_m = 2'b10;
    araddr_m  = {32'h0000_0000, 32'h0000_0000};
    arready_s = 3'b111;
    settle();
    cyc();
    chk("skip_prep_sel",     32'(sel_m),     32'h1);
    chk("skip_prep_arvalid", 32'(arvalid_s), 32'b001);
    cyc();
    arvalid_m = 2'b11;
    araddr_m  = {32'h0001_0004, 32'h0000_0100};
    arready_s = 3'b000;
    settle();
    chk("skip_prep_busy", 32'(busy_s),    32'b001);
    chk("skip_idle",      32'(arvalid_s), 32'h0);
    cyc();
    chk("skip_sel_m1",    32'(sel_m),     32'h1);
    chk("skip_arvalid_s", 32'(arvalid_s), 32'b010);
    chk("skip_no_ready",  32'(arready_m), 32'b00);
    arready_s = 3'b010;
    settle();
    chk("skip_ready_pass", 32'(arready_m), 32'b10);
    cyc();
    arvalid_m = 2'b01;
    settle();
    chk("skip_busy_both", 32'(busy_s), 32'b011);
    cyc();
    chk("skip_m0_waits",  32'(arvalid_s), 32'h0);
    chk("skip_sel_hold",  32'(sel_m),     32'h1);
    rlast_pulse(3'b001);
    chk("skip_s0_free",   32'(busy_s),    32'b010);
    arready_s = 3'b001;
    settle();
    cyc();
    chk("skip_m0_sel",     32'(sel_m),     32'h0);
    chk("skip_m0_arvalid", 32'(arvalid_s), 32'b001);
    cyc();
    arvalid_m = 2'b00;
    settle();
    chk("skip_m0_busy", 32'(busy_s), 32'b011);
    rlast_pulse(3'b011);
    chk("skip_all_free", 32'(busy_s), 32'b000);

    // 5. Default slave via M1 at 0x8000_0000; stray RLAST on idle S0 ignored
    arvalid_m = 2'b10;
    araddr_m  = {32'h8000_0000, 32'h0000_0000};
    arready_s = 3'b100;
    settle();
    cyc();
    chk("dflt_arvalid_s", 32'(arvalid_s), 32'b100);
    chk("dflt_arready_m", 32'(arready_m), 32'b10);
    chk("dflt_sel_m",     32'(sel_m),     32'h1);
    cyc();
    arvalid_m = 2'b00;
    arready_s = 3'b000;
    settle();
    chk("dflt_busy_set", 32'(busy_s), 32'b100);
    rlast_pulse(3'b001);
    chk("dflt_stray_rlast", 32'(busy_s), 32'b100);

    // 6. Backpressure on S1, then asynchronous reset mid-operation
    arvalid_m = 2'b01;
    araddr_m  = {32'h0000_0000, 32'h0001_0000};
    arready_s = 3'b000;
    settle();
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("bp_sel_m",     32'(sel_m),     32'h0);
      chk("bp_arvalid_s", 32'(arvalid_s), 32'b010);
      chk("bp_arready_m", 32'(arready_m), 32'b00);
      chk("bp_busy_s",    32'(busy_s),    32'b100);
      if (k < 2) cyc();
    end
    rst = 1'b1;
    settle();
    chk("arst_arvalid_s", 32'(arvalid_s), 32'h0);
    chk("arst_arready_m", 32'(arready_m), 32'h0);
    chk("arst_sel_m",     32'(sel_m),     32'h0);
    chk("arst_busy_s",    32'(busy_s),    32'h0);
    cyc();
    chk("arst_hold", 32'(arvalid_s), 32'h0);
    rst = 1'b0;
    arvalid_m = 2'b00;
    settle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
